vec_operand_stage: RTL and testbench

VEC_OPERAND_STAGE -- requirements
Module: vec_operand_stage

---
 rtl/vec_pkg.sv | 23 ++
 rtl/vec_broadcast.sv | 22 ++
 rtl/vec_operand_stage.sv | 129 ++++++++++++
 tb/tb_vec_operand_stage.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// Shared definitions for the vector operand stage and the execute-side
// operand-B selector.
//   mode_e       : operand-B source encoding carried with each bundle
//   bundle_hdr_t : per-bundle control header (mode of the bundle)
//   is_legal()   : true for any mode the stage may enqueue
package vec_pkg;

  typedef enum logic [1:0] {
    MODE_VV      = 2'b00,
    MODE_VS_REG  = 2'b01,
    MODE_ILLEGAL = 2'b10,
    MODE_VS_IMM  = 2'b11
  } mode_e;

  typedef struct packed {
    mode_e sel;
  } bundle_hdr_t;

  function automatic logic is_legal(input mode_e m);
    return m != MODE_ILLEGAL;
  endfunction

endpackage

// File: rtl/vec_broadcast.sv
// Combinational lane broadcast.
//   scalar     : LANE_W scalar value, replicated to every lane -> scalar_vec
//   imm        : IMM_W immediate, sign-extended to LANE_W and replicated -> imm_vec
module vec_broadcast #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned LANE_W = 16,
  parameter int unsigned IMM_W  = 8
) (
  input  logic [LANE_W-1:0]       scalar,
  input  logic [IMM_W-1:0]        imm,
  output logic [LANES*LANE_W-1:0] scalar_vec,
  output logic [LANES*LANE_W-1:0] imm_vec
);

  logic [LANE_W-1:0] imm_lane;

  // Sized signed cast sign-extends and stays legal when IMM_W == LANE_W.
  assign imm_lane   = LANE_W'($signed(imm));
  assign scalar_vec = {LANES{scalar}};
  assign imm_vec    = {LANES{imm_lane}};

endmodule

// File: rtl/vec_operand_stage.sv
// Two-entry FIFO-ordered skid buffer between decode and execute that
// captures operand A and all three operand-B candidates per bundle.
//   clk, reset          : clock, synchronous active-high reset
//   in_valid/in_ready   : decode handshake (in_ready registered)
//   in_mode, in_va, in_vb, in_scalar, in_imm : bundle fields
//   flush               : drop every held bundle
//   out_valid/out_ready : execute handshake
//   out_sel, out_a, out_d0..out_d2 : head bundle, zero when out_valid=0
//   illegal_mode        : one-cycle pulse after a mode-10 bundle is rejected
module vec_operand_stage
  import vec_pkg::*;
#(
  parameter int unsigned LANES  = 4,
  parameter int unsigned LANE_W = 16,
  parameter int unsigned IMM_W  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              in_mode,
  input  logic [LANES*LANE_W-1:0] in_va,
  input  logic [LANES*LANE_W-1:0] in_vb,
  input  logic [LANE_W-1:0]       in_scalar,
  input  logic [IMM_W-1:0]        in_imm,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0]              out_sel,
  output logic [LANES*LANE_W-1:0] out_a,
  output logic [LANES*LANE_W-1:0] out_d0,
  output logic [LANES*LANE_W-1:0] out_d1,
  output logic [LANES*LANE_W-1:0] out_d2,
  output logic                    illegal_mode
);

  localparam int unsigned VW = LANES * LANE_W;

  typedef struct packed {
    bundle_hdr_t     hdr;
    logic [VW-1:0]   a;
    logic [VW-1:0]   d0;
    logic [VW-1:0]   d1;
    logic [VW-1:0]   d2;
  } entry_t;

  entry_t        ent_q [2];
  entry_t        ent_new;
  logic [1:0]    occ_q;
  logic [1:0]    occ_d;
  logic          in_ready_q;
  logic          illegal_q;
  logic          handshake;
  logic          mode_ok;
  logic          push;
  logic          pop;
  logic [VW-1:0] scalar_vec;
  logic [VW-1:0] imm_vec;

  vec_broadcast #(
    .LANES  (LANES),
    .LANE_W (LANE_W),
    .IMM_W  (IMM_W)
  ) u_bcast (
    .scalar     (in_scalar),
    .imm        (in_imm),
    .scalar_vec (scalar_vec),
    .imm_vec    (imm_vec)
  );

  always_comb begin
    ent_new         = '0;
    ent_new.hdr.sel = mode_e'(in_mode);
    ent_new.a       = in_va;
    ent_new.d0      = in_vb;
    ent_new.d1      = scalar_vec;
    ent_new.d2      = imm_vec;
  end

  assign handshake = in_valid & in_ready_q;
  assign mode_ok   = is_legal(mode_e'(in_mode));
  assign push      = handshake & mode_ok;
  assign pop       = out_valid & out_ready;

  always_comb begin
    occ_d = occ_q;
    if (push && !pop) begin
      occ_d = occ_q + 2'd1;
    end else if (pop && !push) begin
      occ_d = occ_q - 2'd1;
    end
  end

  // in_ready_q is 0 exactly when occ_q == 2, so a push only lands at occ 0/1;
  // entry 0 is always the head and a pop shifts entry 1 down.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q      <= '0;
      in_ready_q <= 1'b1;
      illegal_q  <= 1'b0;
      ent_q[0]   <= '0;
      ent_q[1]   <= '0;
    end else if (flush) begin
      occ_q      <= '0;
      in_ready_q <= 1'b1;
      illegal_q  <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      in_ready_q <= (occ_d != 2'd2);
      illegal_q  <= handshake & ~mode_ok;
      case ({push, pop})
        2'b10:   ent_q[occ_q[0]] <= ent_new;
        2'b01:   ent_q[0]        <= ent_q[1];
        2'b11:   ent_q[0]        <= ent_new;
        default: ;
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign illegal_mode = illegal_q;
  assign out_valid    = (occ_q != 2'd0);
  assign out_sel      = out_valid ? ent_q[0].hdr.sel : '0;
  assign out_a        = out_valid ? ent_q[0].a       : '0;
  assign out_d0       = out_valid ? ent_q[0].d0      : '0;
  assign out_d1       = out_valid ? ent_q[0].d1      : '0;
  assign out_d2       = out_valid ? ent_q[0].d2      : '0;

endmodule

// File: tb/tb_vec_operand_stage.sv
// Directed scoreboard bench for vec_operand_stage (default parameters).
module tb_vec_operand_stage;

  localparam int unsigned VW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_mode;
  logic [VW-1:0] in_va;
  logic [VW-1:0] in_vb;
  logic [15:0]   in_scalar;
  logic [7:0]    in_imm;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    out_sel;
  logic [VW-1:0] out_a;
  logic [VW-1:0] out_d0;
  logic [VW-1:0] out_d1;
  logic [VW-1:0] out_d2;
  logic          illegal_mode;

  always #5 clk = ~clk;

  vec_operand_stage #(
    .LANES  (4),
    .LANE_W (16),
    .IMM_W  (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_mode      (in_mode),
    .in_va        (in_va),
    .in_vb        (in_vb),
    .in_scalar    (in_scalar),
    .in_imm       (in_imm),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sel      (out_sel),
    .out_a        (out_a),
    .out_d0       (out_d0),
    .out_d1       (out_d1),
    .out_d2       (out_d2),
    .illegal_mode (illegal_mode)
  );

  typedef struct packed {
    logic [1:0]    sel;
    logic [VW-1:0] a;
    logic [VW-1:0] d0;
    logic [VW-1:0] d1;
    logic [VW-1:0] d2;
  } exp_t;

  exp_t sb[$];
  logic m_ill = 1'b0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, check pre-edge outputs against the model, advance the model.
  task automatic step(input logic rst, input logic fl, input logic v, input logic [1:0] mode,
                      input logic [15:0] sc, input logic [7:0] imm, input logic ordy);
    exp_t          e;
    logic [VW-1:0] va;
    logic [VW-1:0] vb;
    bit            acc;
    bit            pp;
    va = {$urandom(), $urandom()};
    vb = {$urandom(), $urandom()};
    reset = rst; flush = fl; in_valid = v; in_mode = mode;
    in_va = va; in_vb = vb; in_scalar = sc; in_imm = imm; out_ready = ordy;
    #1;
    chk("in_ready", {63'd0, in_ready}, {63'd0, sb.size() < 2});
    chk("out_valid", {63'd0, out_valid}, {63'd0, sb.size() > 0});
    chk("illegal_mode", {63'd0, illegal_mode}, {63'd0, m_ill});
    if (sb.size() > 0) begin
      chk("out_sel", {62'd0, out_sel}, {62'd0, sb[0].sel});
      chk("out_a", out_a, sb[0].a);
      chk("out_d0", out_d0, sb[0].d0);
      chk("out_d1", out_d1, sb[0].d1);
      chk("out_d2", out_d2, sb[0].d2);
    end else begin
      chk("out_sel_idle", {62'd0, out_sel}, '0);
      chk("out_a_idle", out_a, '0);
      chk("out_d0_idle", out_d0, '0);
      chk("out_d1_idle", out_d1, '0);
      chk("out_d2_idle", out_d2, '0);
    end
    e.sel = mode;
    e.a   = va;
    e.d0  = vb;
    e.d1  = {4{sc}};
    e.d2  = {4{{8{imm[7]}}, imm}};
    if (rst || fl) begin
      sb.delete();
      m_ill = 1'b0;
    end else begin
      acc = v && (sb.size() < 2);
      pp  = (sb.size() > 0) && ordy;
      if (pp) void'(sb.pop_front());
      if (acc && mode != 2'b10) sb.push_back(e);
      m_ill = acc && (mode == 2'b10);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] legal_modes [3];
    legal_modes[0] = 2'b00;
    legal_modes[1] = 2'b01;
    legal_modes[2] = 2'b11;

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_mode = '0; in_va = '0; in_vb = '0;
    in_scalar = '0; in_imm = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Immediate broadcast, single push
    step(0, 0, 1, 2'b11, 16'h0000, 8'hF3, 0);
    chk("imm_valid", {63'd0, out_valid}, 64'd1);
    chk("imm_d2", out_d2, 64'hFFF3_FFF3_FFF3_FFF3);
    chk("imm_sel", {62'd0, out_sel}, 64'd3);
    step(0, 0, 0, 2'b00, 16'h0000, 8'h00, 1);

    // Backpressure: three offered, two accepted, third waits
    step(0, 0, 1, 2'b00, 16'h1111, 8'h11, 0);
    step(0, 0, 1, 2'b01, 16'h2222, 8'h22, 0);
    chk("bp_full_ready", {63'd0, in_ready}, 64'd0);
    step(0, 0, 1, 2'b11, 16'h3333, 8'h83, 0);
    step(0, 0, 1, 2'b11, 16'h3333, 8'h83, 0);
    step(0, 0, 1, 2'b11, 16'h3333, 8'h83, 1);
    step(0, 0, 1, 2'b11, 16'h3333, 8'h83, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 2'b00, 16'h0000, 8'h00, 1);
    chk("bp_drained", {63'd0, out_valid}, 64'd0);

    // Streaming push+pop at occupancy 1
    step(0, 0, 1, 2'b00, 16'hA5A5, 8'h7F, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1, legal_modes[$urandom_range(0, 2)], 16'($urandom()), 8'($urandom()), 1);
      chk("stream_occ1_ready", {63'd0, in_ready}, 64'd1);
      chk("stream_occ1_valid", {63'd0, out_valid}, 64'd1);
    end
    for (int i = 0; i < 2; i++) step(0, 0, 0, 2'b00, 16'h0000, 8'h00, 1);

    // Illegal mode at occupancy 0
    step(0, 0, 1, 2'b10, 16'hDEAD, 8'hBE, 0);
    chk("illegal_pulse", {63'd0, illegal_mode}, 64'd1);
    chk("illegal_no_valid", {63'd0, out_valid}, 64'd0);
    step(0, 0, 0, 2'b00, 16'h0000, 8'h00, 0);
    chk("illegal_one_cycle", {63'd0, illegal_mode}, 64'd0);

    // Illegal mode behind a held bundle
    step(0, 0, 1, 2'b01, 16'h0F0F, 8'h01, 0);
    step(0, 0, 1, 2'b10, 16'h0000, 8'h00, 0);
    step(0, 0, 0, 2'b00, 16'h0000, 8'h00, 1);

    // Flush at occupancy 2 with a concurrent push
    step(0, 0, 1, 2'b00, 16'h4444, 8'h44, 0);
    step(0, 0, 1, 2'b11, 16'h5555, 8'hC5, 0);
    step(0, 1, 1, 2'b00, 16'h6666, 8'h66, 1);
    chk("flush_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_ready", {63'd0, in_ready}, 64'd1);
    step(0, 0, 0, 2'b00, 16'h0000, 8'h00, 1);

    // Scalar broadcast, then reset while full
    step(0, 0, 1, 2'b01, 16'h1234, 8'h00, 0);
    chk("scalar_d1", out_d1, 64'h1234_1234_1234_1234);
    step(0, 0, 1, 2'b00, 16'h7777, 8'h77, 0);
    step(1, 0, 1, 2'b11, 16'h8888, 8'h88, 1);
    chk("reset_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_ready", {63'd0, in_ready}, 64'd1);
    step(0, 0, 0, 2'b00, 16'h0000, 8'h00, 1);
    step(0, 0, 1, 2'b11, 16'h0000, 8'h05, 1);
    step(0, 0, 0, 2'b00, 16'h0000, 8'h00, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
